// File: rtl/sram_cycle_ctrl_if.sv
// sram_cycle_ctrl_if: registered IO-bus port of the SRAM cycle controller.
// Ports: bus_we/bus_rd one-cycle strobes, bus_sel register select, bus_wd write data,
//        bus_rdata combinational read data for the selected register.
interface sram_cycle_ctrl_if;
   logic        bus_we;
   logic        bus_rd;
   logic [1:0]  bus_sel;
   logic [15:0] bus_wd;
   logic [15:0] bus_rdata;

   modport master (output bus_we, bus_rd, bus_sel, bus_wd, input bus_rdata);
   modport slave  (input bus_we, bus_rd, bus_sel, bus_wd, output bus_rdata);
endinterface

// File: rtl/sram_cycle_ctrl.sv
// sram_cycle_ctrl: sequences nCS/nWE/nOE read and write cycles on an async byte-wide SRAM.
// Latency: write busy T_SETUP+T_WE+1 cycles, read busy T_RD cycles; all pins registered.
// Backpressure: none; a start request while busy is dropped and flagged in STAT.ovr.
// Ports: clk, resetq (async active-low), bus (IO register port: 0 ADDR_LO, 1 ADDR_HI,
//        2 DATA, 3 CTRL/STAT), sram_a/sram_d_o/sram_d_oe/sram_d_i/sram_ncs/sram_nwe/sram_noe pins.
module sram_cycle_ctrl #(
   parameter int AW      = 18,
   parameter int T_SETUP = 1,
   parameter int T_WE    = 2,
   parameter int T_RD    = 3
) (
   input  logic                clk,
   input  logic                resetq,
   sram_cycle_ctrl_if.slave    bus,
   output logic [AW-1:0]       sram_a,
   output logic [7:0]          sram_d_o,
   output logic                sram_d_oe,
   input  logic [7:0]          sram_d_i,
   output logic                sram_ncs,
   output logic                sram_nwe,
   output logic                sram_noe
);

   localparam logic [7:0] SETUP_LAST = 8'(T_SETUP - 1);
   localparam logic [7:0] WE_LAST    = 8'(T_WE - 1);
   localparam logic [7:0] RD_LAST    = 8'(T_RD - 1);

   typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACC} state_t;

   state_t        state, state_n;
   logic [7:0]    cnt, cnt_n;
   logic [AW-1:0] addr;
   logic          ainc;
   logic [7:0]    rbyte;
   logic          valid;
   logic          ovr;
   logic          done;      // cycle finishes this clock (next state IDLE)
   logic          sample;    // last read-access cycle: capture pad data
   logic          idle;
   logic          start_wr;
   logic          start_rd;
   logic [15:0]   addr_hi_rd;

   assign idle     = (state == IDLE);
   assign start_wr = bus.bus_we && (bus.bus_sel == 2'd2);
   // Read starts from CTRL bit0, or from a DATA read in auto-increment mode (streaming).
   // The streaming form only fires when idle, so it never counts as an overrun.
   assign start_rd = (bus.bus_we && (bus.bus_sel == 2'd3) && bus.bus_wd[0]) ||
                     (bus.bus_rd && (bus.bus_sel == 2'd2) && ainc && idle);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done    = 1'b0;
      sample  = 1'b0;
      case (state)
         IDLE: begin
            if (start_wr) begin
               state_n = W_SETUP;
               cnt_n   = 8'd0;
            end else if (start_rd) begin
               state_n = R_ACC;
               cnt_n   = 8'd0;
            end
         end
         W_SETUP: begin
            if (cnt == SETUP_LAST) begin
               state_n = W_PULSE;
               cnt_n   = 8'd0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         W_PULSE: begin
            if (cnt == WE_LAST) begin
               state_n = W_HOLD;
               cnt_n   = 8'd0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         W_HOLD: begin
            state_n = IDLE;
            done    = 1'b1;
         end
         R_ACC: begin
            if (cnt == RD_LAST) begin
               state_n = IDLE;
               done    = 1'b1;
               sample  = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Pin strobes are decoded from the next state and registered, so each pin
   // changes once per clock straight from a flop: no decode glitches reach the SRAM.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         sram_ncs  <= 1'b1;
         sram_nwe  <= 1'b1;
         sram_noe  <= 1'b1;
         sram_d_oe <= 1'b0;
         sram_a    <= '0;
         sram_d_o  <= 8'd0;
      end else begin
         sram_ncs  <= (state_n == IDLE);
         sram_nwe  <= (state_n != W_PULSE);
         sram_noe  <= (state_n != R_ACC);
         sram_d_oe <= (state_n == W_SETUP) || (state_n == W_PULSE) || (state_n == W_HOLD);
         // Address/data are captured only on start so later ADDR writes cannot disturb a cycle.
         if (idle && start_wr) begin
            sram_a   <= addr;
            sram_d_o <= bus.bus_wd[7:0];
         end else if (idle && start_rd) begin
            sram_a <= addr;
         end
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         addr  <= '0;
         ainc  <= 1'b0;
         rbyte <= 8'd0;
         valid <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         // A bus write to either address half beats the completion increment.
         if (bus.bus_we && (bus.bus_sel == 2'd0)) begin
            addr[15:0] <= bus.bus_wd;
         end else if (bus.bus_we && (bus.bus_sel == 2'd1)) begin
            addr[AW-1:16] <= bus.bus_wd[AW-17:0];
            ainc          <= bus.bus_wd[15];
         end else if (done && ainc) begin
            addr <= addr + 1'b1;
         end

         if (sample) begin
            rbyte <= sram_d_i;
            valid <= 1'b1;
         end else if (bus.bus_rd && (bus.bus_sel == 2'd2)) begin
            valid <= 1'b0;
         end

         if ((start_wr || start_rd) && !idle) begin
            ovr <= 1'b1;
         end else if (bus.bus_rd && (bus.bus_sel == 2'd3)) begin
            ovr <= 1'b0;
         end
      end
   end

   always_comb begin
      addr_hi_rd              = '0;
      addr_hi_rd[AW-17:0]     = addr[AW-1:16];
      addr_hi_rd[15]          = ainc;
   end

   always_comb begin
      bus.bus_rdata = 16'd0;
      case (bus.bus_sel)
         2'd0:    bus.bus_rdata = addr[15:0];
         2'd1:    bus.bus_rdata = addr_hi_rd;
         2'd2:    bus.bus_rdata = {8'd0, rbyte};
         default: bus.bus_rdata = {13'd0, ovr, valid, !idle};
      endcase
   end

endmodule

// File: tb/tb_sram_cycle_ctrl.sv
// tb_sram_cycle_ctrl: self-checking bench for sram_cycle_ctrl with an SRAM device model,
// pin-protocol monitor and a register-level reference model of the peripheral.
module tb_sram_cycle_ctrl;
   localparam int AW      = 18;
   localparam int T_SETUP = 1;
   localparam int T_WE    = 2;
   localparam int T_RD    = 3;
   localparam int MEMSZ   = 1 << AW;

   logic          clk = 1'b0;
   logic          resetq = 1'b0;
   logic [AW-1:0] sram_a;
   logic [7:0]    sram_d_o;
   logic          sram_d_oe;
   logic [7:0]    sram_d_i;
   logic          sram_ncs, sram_nwe, sram_noe;

   sram_cycle_ctrl_if bus ();

   sram_cycle_ctrl #(.AW(AW), .T_SETUP(T_SETUP), .T_WE(T_WE), .T_RD(T_RD)) dut (
      .clk(clk), .resetq(resetq), .bus(bus),
      .sram_a(sram_a), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe), .sram_d_i(sram_d_i),
      .sram_ncs(sram_ncs), .sram_nwe(sram_nwe), .sram_noe(sram_noe)
   );

   always #5 clk = ~clk;

   // SRAM device contents and the reference model's expectation of them
   logic [7:0] sram_mem [MEMSZ];
   logic [7:0] ref_mem  [MEMSZ];
   int         viol = 0;
   int         nwe_low_cycles = 0;

   // reference model of the register file
   logic [AW-1:0] m_addr;
   logic          m_ainc;
   logic [7:0]    m_rbyte;
   logic          m_valid, m_ovr;

   int n_cmp = 0;
   int n_fail = 0;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37) ^ (i >> 9));
   endfunction

   assign sram_d_i = sram_noe ? 8'h00 : sram_mem[sram_a];

   // SRAM device + protocol monitor: writes land on each low-nWE cycle
   initial begin
      for (int i = 0; i < MEMSZ; i++) sram_mem[i] = init_byte(i);
      forever begin
         @(negedge clk);
         if (resetq) begin
            if (!sram_nwe && !sram_noe) viol++;
            if (sram_d_oe && !sram_noe) viol++;
            if (!sram_nwe && sram_ncs) viol++;
            if (!sram_nwe) begin
               nwe_low_cycles++;
               sram_mem[sram_a] = sram_d_o;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // ---------------- bus drivers (no checking) ----------------
   task automatic wr(input logic [1:0] sel, input logic [15:0] d);
      bus.bus_sel = sel; bus.bus_wd = d; bus.bus_we = 1'b1;
      @(posedge clk); #1;
      bus.bus_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] sel, output logic [15:0] d);
      bus.bus_sel = sel; bus.bus_rd = 1'b1;
      #2 d = bus.bus_rdata;
      @(posedge clk); #1;
      bus.bus_rd = 1'b0;
   endtask

   task automatic peek(input logic [1:0] sel, output logic [15:0] d);
      bus.bus_sel = sel;
      #1 d = bus.bus_rdata;
   endtask

   task automatic wait_idle(output bit timed_out);
      logic [15:0] s;
      timed_out = 1'b1;
      for (int k = 0; k < 64; k++) begin
         peek(2'd3, s);
         if (s[0] == 1'b0) begin
            timed_out = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic m_inc();
      if (m_ainc) m_addr = m_addr + 1'b1;
   endtask

   task automatic m_start_read();
      m_rbyte = ref_mem[m_addr];
      m_valid = 1'b1;
      m_inc();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] d;
      bus.bus_we = 1'b0; bus.bus_rd = 1'b0; bus.bus_sel = 2'd0; bus.bus_wd = 16'd0;
      resetq = 1'b0;
      m_addr = '0; m_ainc = 1'b0; m_rbyte = 8'd0; m_valid = 1'b0; m_ovr = 1'b0;
      #12;
      n_cmp++; if ({sram_ncs, sram_nwe, sram_noe, sram_d_oe} !== 4'b1110) begin n_fail++;
         $display("FAIL reset_pins: got %b want 1110", {sram_ncs, sram_nwe, sram_noe, sram_d_oe}); end
      n_cmp++; if ({sram_a, sram_d_o} !== '0) begin n_fail++;
         $display("FAIL reset_a_do: got a=%h do=%h want 0", sram_a, sram_d_o); end
      for (int s = 0; s < 4; s++) begin
         peek(2'(s), d);
         n_cmp++; if (d !== 16'h0000) begin n_fail++;
            $display("FAIL reset_reg%0d: got %h want 0000", s, d); end
      end
      @(negedge clk); resetq = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      logic [7:0] g_busy, g_nwe, g_ncs, g_doe, e_busy, e_nwe;
      logic [AW-1:0] a1;
      logic [7:0] d1;
      logic [15:0] s;
      wr(2'd0, 16'h1234);
      wr(2'd1, 16'h0001);
      m_addr = 18'h11234; m_ainc = 1'b0;
      wr(2'd2, 16'h00A5);
      g_busy = '0; g_nwe = '1; g_ncs = '1; g_doe = '0; e_busy = '0; e_nwe = '1;
      a1 = '0; d1 = '0;
      for (int c = 1; c <= 6; c++) begin
         peek(2'd3, s);
         g_busy[c] = s[0]; g_nwe[c] = sram_nwe; g_ncs[c] = sram_ncs; g_doe[c] = sram_d_oe;
         if (c == 1) begin a1 = sram_a; d1 = sram_d_o; end
         e_busy[c] = (c <= T_SETUP + T_WE + 1);
         e_nwe[c]  = !((c >= T_SETUP + 1) && (c <= T_SETUP + T_WE));
         @(posedge clk); #1;
      end
      ref_mem[m_addr] = 8'hA5;
      n_cmp++; if (g_busy !== e_busy) begin n_fail++; $display("FAIL wr_busy: got %b want %b", g_busy, e_busy); end
      n_cmp++; if (g_nwe !== e_nwe) begin n_fail++; $display("FAIL wr_nwe: got %b want %b", g_nwe, e_nwe); end
      n_cmp++; if (g_ncs !== ~e_busy) begin n_fail++; $display("FAIL wr_ncs: got %b want %b", g_ncs, ~e_busy); end
      n_cmp++; if (g_doe !== e_busy) begin n_fail++; $display("FAIL wr_doe: got %b want %b", g_doe, e_busy); end
      n_cmp++; if ({a1, d1} !== {18'h11234, 8'hA5}) begin n_fail++;
         $display("FAIL wr_addr_data: got a=%h d=%h want a=11234 d=a5", a1, d1); end
      n_cmp++; if (sram_mem[18'h11234] !== 8'hA5) begin n_fail++;
         $display("FAIL wr_mem: got %h want a5", sram_mem[18'h11234]); end
   endtask

   task automatic test_read();
      logic [7:0] g_noe, e_noe;
      logic [15:0] d;
      bit to;
      wr(2'd2, 16'h005A);
      wait_idle(to);
      ref_mem[m_addr] = 8'h5A;
      wr(2'd3, 16'h0001);
      g_noe = '1; e_noe = '1;
      for (int c = 1; c <= 6; c++) begin
         g_noe[c] = sram_noe;
         e_noe[c] = !(c <= T_RD);
         @(posedge clk); #1;
      end
      m_start_read();
      n_cmp++; if (g_noe !== e_noe) begin n_fail++; $display("FAIL rd_noe: got %b want %b", g_noe, e_noe); end
      rd(2'd3, d);
      n_cmp++; if (d !== 16'h0002) begin n_fail++; $display("FAIL rd_stat_valid: got %h want 0002", d); end
      rd(2'd2, d); m_valid = 1'b0;
      n_cmp++; if (d !== 16'h005A) begin n_fail++; $display("FAIL rd_data: got %h want 005a", d); end
      rd(2'd3, d);
      n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rd_stat_clr: got %h want 0000", d); end
   endtask

   task automatic test_autoinc();
      logic [15:0] d;
      logic [7:0] bytes [3];
      bit to;
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
      wr(2'd1, 16'h8003);
      wr(2'd0, 16'hFFFE);
      m_addr = 18'h3FFFE; m_ainc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr(2'd2, {8'h00, bytes[i]});
         ref_mem[m_addr] = bytes[i]; m_inc();
         wait_idle(to);
         n_cmp++; if (to) begin n_fail++; $display("FAIL ainc_idle%0d: got busy want idle", i); end
      end
      n_cmp++; if ({sram_mem[18'h3FFFE], sram_mem[18'h3FFFF], sram_mem[0]} !== 24'h112233) begin n_fail++;
         $display("FAIL ainc_mem: got %h %h %h want 11 22 33", sram_mem[18'h3FFFE], sram_mem[18'h3FFFF], sram_mem[0]); end
      rd(2'd0, d);
      n_cmp++; if (d !== 16'h0001) begin n_fail++; $display("FAIL ainc_lo: got %h want 0001", d); end
      rd(2'd1, d);
      n_cmp++; if (d !== 16'h8000) begin n_fail++; $display("FAIL ainc_hi: got %h want 8000", d); end
   endtask

   task automatic test_addr_write_wins();
      logic [15:0] d;
      bit to;
      wr(2'd2, 16'h0044);
      ref_mem[m_addr] = 8'h44;
      repeat (T_SETUP + T_WE) @(posedge clk);
      #1 wr(2'd0, 16'h0100);
      m_addr = 18'h00100;
      wait_idle(to);
      rd(2'd0, d);
      n_cmp++; if (d !== 16'h0100) begin n_fail++; $display("FAIL addr_wins: got %h want 0100", d); end
      n_cmp++; if (sram_mem[1] !== 8'h44) begin n_fail++; $display("FAIL addr_wins_mem: got %h want 44", sram_mem[1]); end
   endtask

   task automatic test_overrun();
      logic [15:0] d;
      int n0;
      bit to;
      wr(2'd1, 16'h0000);
      m_ainc = 1'b0; m_addr[AW-1:16] = '0;
      n0 = nwe_low_cycles;
      wr(2'd2, 16'h0077);
      wr(2'd2, 16'h0088);
      ref_mem[m_addr] = 8'h77;
      rd(2'd3, d);
      n_cmp++; if (d !== 16'h0005) begin n_fail++; $display("FAIL ovr_stat_busy: got %h want 0005", d); end
      wait_idle(to);
      rd(2'd3, d);
      n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL ovr_stat_clr: got %h want 0000", d); end
      n_cmp++; if (nwe_low_cycles - n0 !== T_WE) begin n_fail++;
         $display("FAIL ovr_single_pulse: got %0d low cycles want %0d", nwe_low_cycles - n0, T_WE); end
      n_cmp++; if (sram_mem[m_addr] !== 8'h77) begin n_fail++;
         $display("FAIL ovr_mem: got %h want 77", sram_mem[m_addr]); end
   endtask

   task automatic test_stream();
      logic [15:0] d;
      logic [AW-1:0] a, ea;
      logic [31:0] v;
      bit to;
      v = $urandom; a = v[AW-1:0];
      wr(2'd0, a[15:0]);
      wr(2'd1, {1'b1, 13'd0, a[17:16]});
      m_addr = a; m_ainc = 1'b1;
      wr(2'd3, 16'h0001); m_start_read();
      wait_idle(to);
      for (int i = 0; i < 4; i++) begin
         ea = a + AW'(i);
         rd(2'd2, d);
         n_cmp++; if (d !== {8'h00, ref_mem[ea]}) begin n_fail++;
            $display("FAIL stream_byte%0d: got %h want %h", i, d, {8'h00, ref_mem[ea]}); end
         m_valid = 1'b0; m_start_read();
         if (i == 3) begin
            ea = a + AW'(4);
            rd(2'd0, d);
            n_cmp++; if (d !== ea[15:0]) begin n_fail++; $display("FAIL stream_addr: got %h want %h", d, ea[15:0]); end
         end
         wait_idle(to);
         n_cmp++; if (to) begin n_fail++; $display("FAIL stream_idle%0d: got busy want idle", i); end
      end
      rd(2'd0, d);
      n_cmp++; if (d !== m_addr[15:0]) begin n_fail++; $display("FAIL stream_addr_end: got %h want %h", d, m_addr[15:0]); end
   endtask

   task automatic test_random();
      logic [15:0] d;
      logic [31:0] v;
      logic [7:0] b;
      bit to;
      for (int n = 0; n < 200; n++) begin
         v = $urandom; b = v[27:20];
         case ($urandom_range(0, 6))
            0: begin
               if ($urandom_range(0, 3) == 0) v[17:0] = 18'h3FFFF - 18'($urandom_range(0, 2));
               wr(2'd0, v[15:0]);
               wr(2'd1, {v[31], 13'd0, v[17:16]});
               m_addr = v[17:0]; m_ainc = v[31];
            end
            1: begin
               wr(2'd2, {8'h00, b}); ref_mem[m_addr] = b; m_inc();
               wait_idle(to);
            end
            2: begin
               wr(2'd3, 16'h0001); m_start_read();
               wait_idle(to);
            end
            3: begin
               rd(2'd2, d);
               n_cmp++; if (d !== {8'h00, m_rbyte}) begin n_fail++;
                  $display("FAIL rnd_data%0d: got %h want %h", n, d, {8'h00, m_rbyte}); end
               m_valid = 1'b0;
               if (m_ainc) m_start_read();
               wait_idle(to);
            end
            4: begin
               rd(2'd3, d);
               n_cmp++; if (d !== {13'd0, m_ovr, m_valid, 1'b0}) begin n_fail++;
                  $display("FAIL rnd_stat%0d: got %h want %h", n, d, {13'd0, m_ovr, m_valid, 1'b0}); end
               m_ovr = 1'b0;
            end
            5: begin
               rd(2'd0, d);
               n_cmp++; if (d !== m_addr[15:0]) begin n_fail++;
                  $display("FAIL rnd_addr_lo%0d: got %h want %h", n, d, m_addr[15:0]); end
               rd(2'd1, d);
               n_cmp++; if (d !== {m_ainc, 13'd0, m_addr[17:16]}) begin n_fail++;
                  $display("FAIL rnd_addr_hi%0d: got %h want %h", n, d, {m_ainc, 13'd0, m_addr[17:16]}); end
            end
            default: begin
               wr(2'd2, {8'h00, b}); ref_mem[m_addr] = b; m_inc();
               wr(2'd3, 16'h0001); m_ovr = 1'b1;
               wait_idle(to);
            end
         endcase
         n_cmp++; if (to) begin n_fail++; $display("FAIL rnd_idle%0d: got busy want idle", n); end
         to = 1'b0;
      end
   endtask

   task automatic test_reset_mid_write();
      logic [15:0] d;
      wr(2'd2, 16'h0099);
      repeat (T_SETUP) @(posedge clk);
      #1;
      n_cmp++; if (sram_nwe !== 1'b0) begin n_fail++; $display("FAIL midrst_in_pulse: got nwe=%b want 0", sram_nwe); end
      #2 resetq = 1'b0;
      #1;
      n_cmp++; if ({sram_ncs, sram_nwe, sram_noe, sram_d_oe} !== 4'b1110) begin n_fail++;
         $display("FAIL midrst_pins: got %b want 1110", {sram_ncs, sram_nwe, sram_noe, sram_d_oe}); end
      @(negedge clk); resetq = 1'b1;
      @(posedge clk); #1;
      m_addr = '0; m_ainc = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_rbyte = 8'd0;
      peek(2'd3, d);
      n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_stat: got %h want 0000", d); end
      peek(2'd0, d);
      n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_addr_lo: got %h want 0000", d); end
      peek(2'd1, d);
      n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_addr_hi: got %h want 0000", d); end
   endtask

   task automatic test_protocol();
      n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL pin_protocol: got %0d violations want 0", viol); end
   endtask

   initial begin
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_byte(i);
      test_reset();
      test_write();
      test_read();
      test_autoinc();
      test_addr_write_wins();
      test_overrun();
      test_stream();
      test_random();
      test_protocol();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
